lsu_dbus_ctrl: RTL and testbench
================================

Name: lsu_dbus_ctrl

Overview:
- Parametrised load/store access controller between the EX/MEM pipeline register and the data bus (dbus).
- Captures one memory op per access and drives the dbus request until `data_ok`.
- Generates byte strobes and lane-shifted write data; aligns and sign/zero-extends load data.
- Raises a pipeline stall for the whole access, then hands back a one-cycle response.

Parameters:
- XLEN, 64, data width in bits; must be 32 or 64. BYTES = XLEN/8 and OFS_W = log2(BYTES) are derived.
- ADDR_W, 64, bus address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  memory op present in MEM stage
- req_write  in  1  1 = store, 0 = load
- req_size  in  3  log2 of access bytes (0=B, 1=H, 2=W, 3=D)
- req_unsigned  in  1  zero-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, LSB-aligned
- stall  out  1  hold pipeline
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  XLEN  extended load data (0 for stores)
- misalign  out  1  illegal or misaligned request flag
- dreq_valid  out  1  bus request valid
- dreq_addr  out  ADDR_W  bus address
- dreq_size  out  3  bus size code
- dreq_strobe  out  BYTES  byte write enables
- dreq_data  out  XLEN  lane-shifted write data
- dresp_data_ok  in  1  bus data phase done
- dresp_data  in  XLEN  raw bus read data

Behaviour:
- Reset (async, immediate):
  - State = IDLE; all registered outputs 0.
  - dreq_valid drops immediately, abandoning any in-flight access.
- State IDLE:
  - Illegal request: req_valid with req_size > OFS_W, or addr[req_size-1:0] != 0.
    - misalign = 1 combinationally; stall = 0; no bus request; stay in IDLE.
  - Legal request: stall = 1 combinationally.
    - Latch write, size, unsigned, addr, wdata.
    - Next state = REQ.
- State REQ:
  - dreq_valid = 1; dreq_* driven only from latched registers, stable for the whole state.
  - stall = 1; req_* inputs are ignored.
  - On dresp_data_ok: capture the extended result into rsp_rdata; next state = DONE.
  - data_ok in the same cycle the state becomes REQ is not possible; the earliest completion is the next cycle.
- State DONE (exactly 1 cycle):
  - rsp_valid = 1, stall = 0, dreq_valid = 0; pipeline advances this edge.
  - Next state = IDLE unconditionally.
  - A new req_valid is not sampled until IDLE, so back-to-back ops cost 1 idle cycle minimum.
- Latency: load/store completes at (bus latency + 2) cycles after req_valid is first seen.
- Write path:
  - ofs = addr[OFS_W-1:0]
  - dreq_strobe = ((1 << (1 << size)) - 1) << ofs; all zeros for loads.
  - dreq_data = wdata << (8*ofs).
- Read path:
  - raw = dresp_data >> (8*ofs), masked to 8 << size bits.
  - Sign-extend from bit (8 << size) - 1 unless unsigned; size == OFS_W passes raw unchanged.
- dreq_size = latched size; dreq_addr = latched addr, not realigned.
- rsp_rdata holds its value until the next capture.

Optional Feature:
- Macro: LSU_PERF_CNT_EN
- When defined, two 32-bit output ports are added; both clear on reset and wrap modulo 2^32:
  - perf_acc_cnt: increments on each rsp_valid.
  - perf_wait_cyc: increments every cycle in REQ.
- When undefined, the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- XLEN=64, LB from addr 0x1003, dresp_data=0x0000_0000_8000_0000:
  - stall high 2+N cycles; rsp_rdata=0xFFFF_FFFF_FFFF_FF80 (byte 3 = 0x80); rsp_valid pulses once.
- SH wdata=0xBEEF to addr 0x1006:
  - dreq_strobe=0xC0, dreq_data=0xBEEF_0000_0000_0000, dreq_size=1; dreq_* stable across 3 wait cycles.
- LW to addr 0x1002:
  - misalign=1 same cycle; stall=0; dreq_valid never asserted.
- LWU at 0x1004, dresp_data=0xF000_0000_0000_0000 with data_ok after 1 cycle:
  - rsp_rdata=0x0000_0000_F000_0000; DONE then IDLE; a second LD issued immediately starts REQ one cycle after DONE.
- Reset asserted mid-REQ:
  - dreq_valid=0 and stall=0 without a clock edge.
  - After release with req_valid=0, all outputs remain 0.
- With LSU_PERF_CNT_EN, 3 accesses with 2 wait cycles each:
  - perf_acc_cnt=3, perf_wait_cyc=6.

Source files
------------

// File: rtl/lsu_dbus_ctrl.sv
// rtl/lsu_dbus_ctrl.sv - load/store access controller between the MEM stage and the data bus
// Optional LSU_PERF_CNT_EN adds access and bus-wait performance counters.
module lsu_dbus_ctrl #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req_valid,
  input  logic                i_req_write,
  input  logic [2:0]          i_req_size,
  input  logic                i_req_unsigned,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [XLEN-1:0]     i_req_wdata,
  output logic                o_stall,
  output logic                o_rsp_valid,
  output logic [XLEN-1:0]     o_rsp_rdata,
  output logic                o_misalign,
  output logic                o_dreq_valid,
  output logic [ADDR_W-1:0]   o_dreq_addr,
  output logic [2:0]          o_dreq_size,
  output logic [XLEN/8-1:0]   o_dreq_strobe,
  output logic [XLEN-1:0]     o_dreq_data,
  input  logic                i_dresp_data_ok,
  input  logic [XLEN-1:0]     i_dresp_data
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]         o_perf_acc_cnt,
  output logic [31:0]         o_perf_wait_cyc
`endif
);

  localparam int BYTES = XLEN / 8;
  localparam int OFS_W = $clog2(BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_write;
  logic [2:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_W-1:0]     r_addr;
  logic [BYTES-1:0]      r_strobe;
  logic [XLEN-1:0]       r_wdata;
  logic                  r_dreq_valid;
  logic                  r_rsp_valid;
  logic [XLEN-1:0]       r_rsp_rdata;

  logic [7:0]            w_align_mask;
  logic                  w_illegal;
  logic                  w_idle_req;
  logic                  w_accept;
  logic [OFS_W-1:0]      w_ofs;
  logic [4:0]            w_nbytes;
  logic [BYTES-1:0]      w_strobe;
  logic [XLEN-1:0]       w_wdata_sh;
  logic [OFS_W-1:0]      w_rd_ofs;
  logic [6:0]            w_bits;
  logic                  w_full;
  logic [XLEN-1:0]       w_rd_shift;
  logic [XLEN-1:0]       w_rd_mask;
  logic                  w_rd_sign;
  logic [XLEN-1:0]       w_rd_ext;

  // Legality: size must fit the datapath and the address must be naturally aligned.
  assign w_align_mask = 8'((9'd1 << i_req_size) - 9'd1);
  assign w_illegal    = (i_req_size > 3'(OFS_W)) || (|(i_req_addr[7:0] & w_align_mask));
  assign w_idle_req   = !i_reset && (r_state == S_IDLE) && i_req_valid;
  assign w_accept     = w_idle_req && !w_illegal;

  assign o_misalign   = w_idle_req && w_illegal;
  assign o_stall      = w_accept || (r_state == S_REQ);

  assign w_ofs        = i_req_addr[OFS_W-1:0];
  assign w_nbytes     = 5'd1 << i_req_size[1:0];
  assign w_strobe     = i_req_write
                        ? (BYTES'((BYTES+1)'(1) << w_nbytes) - BYTES'(1)) << w_ofs
                        : '0;
  assign w_wdata_sh   = i_req_wdata << {w_ofs, 3'b000};

  // Load alignment: shift the addressed lanes down, mask to the access width, then extend.
  assign w_rd_ofs     = r_addr[OFS_W-1:0];
  assign w_rd_shift   = i_dresp_data >> {w_rd_ofs, 3'b000};
  assign w_bits       = 7'd8 << r_size[1:0];
  assign w_full       = (r_size >= 3'(OFS_W));
  assign w_rd_mask    = w_full ? '1 : ((XLEN'(1) << w_bits) - XLEN'(1));
  assign w_rd_sign    = !r_unsigned && !w_full &&
                        (|(w_rd_shift & (w_rd_mask ^ (w_rd_mask >> 1))));
  assign w_rd_ext     = (w_rd_shift & w_rd_mask) | (w_rd_sign ? ~w_rd_mask : '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_strobe     <= '0;
      r_wdata      <= '0;
      r_dreq_valid <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (w_accept) begin
            r_write      <= i_req_write;
            r_size       <= i_req_size;
            r_unsigned   <= i_req_unsigned;
            r_addr       <= i_req_addr;
            r_strobe     <= w_strobe;
            r_wdata      <= w_wdata_sh;
            r_dreq_valid <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_dresp_data_ok) begin
            r_rsp_rdata  <= r_write ? '0 : w_rd_ext;
            r_dreq_valid <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_dreq_valid <= 1'b0;
          r_rsp_valid  <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign o_dreq_valid  = r_dreq_valid;
  assign o_dreq_addr   = r_addr;
  assign o_dreq_size   = r_size;
  assign o_dreq_strobe = r_strobe;
  assign o_dreq_data   = r_wdata;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] r_perf_acc_cnt;
  logic [31:0] r_perf_wait_cyc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_perf_acc_cnt  <= '0;
      r_perf_wait_cyc <= '0;
    end else begin
      if (r_rsp_valid)
        r_perf_acc_cnt <= r_perf_acc_cnt + 32'd1;
      if (r_state == S_REQ)
        r_perf_wait_cyc <= r_perf_wait_cyc + 32'd1;
    end
  end

  assign o_perf_acc_cnt  = r_perf_acc_cnt;
  assign o_perf_wait_cyc = r_perf_wait_cyc;
`endif

endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
// tb/tb_lsu_dbus_ctrl.sv - randomized self-checking bench for lsu_dbus_ctrl
// Optional LSU_PERF_CNT_EN also exercises the performance counters.
module tb_lsu_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_unsigned;
  logic [2:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        stall, rsp_valid, misalign, dreq_valid;
  logic [63:0] rsp_rdata, dreq_addr, dreq_data;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_acc_cnt, perf_wait_cyc;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_dbus_ctrl #(.XLEN(64), .ADDR_W(64)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .i_req_write(req_write), .i_req_size(req_size),
    .i_req_unsigned(req_unsigned), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_stall(stall), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_misalign(misalign),
    .o_dreq_valid(dreq_valid), .o_dreq_addr(dreq_addr), .o_dreq_size(dreq_size),
    .o_dreq_strobe(dreq_strobe), .o_dreq_data(dreq_data),
    .i_dresp_data_ok(dresp_data_ok), .i_dresp_data(dresp_data)
`ifdef LSU_PERF_CNT_EN
    , .o_perf_acc_cnt(perf_acc_cnt), .o_perf_wait_cyc(perf_wait_cyc)
`endif
  );

  // Reference model: plain byte arithmetic on a 64-bit little-endian bus.
  function automatic logic [7:0] m_strobe(bit w, int sz, logic [63:0] addr);
    int nb = 1 << sz;
    int s = ((1 << nb) - 1) << int'(addr % 8);
    if (!w) return 8'h00;
    return s[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(logic [63:0] wd, logic [63:0] addr);
    return wd << (8 * int'(addr % 8));
  endfunction

  function automatic logic [63:0] m_rdata(bit w, int sz, bit uns, logic [63:0] addr, logic [63:0] d);
    int nb = 1 << sz;
    logic [63:0] v = d >> (8 * int'(addr % 8));
    if (w) return 64'd0;
    if (nb < 8) begin
      v = v % (64'd1 << (8 * nb));
      if (!uns && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    end
    return v;
  endfunction

  // Drives one op and a bus that answers `lat` cycles after the request appears; returns observations.
  task automatic run_access(input bit w, input logic [2:0] sz, input bit uns, input logic [63:0] addr,
                            input logic [63:0] wd, input int lat, input logic [63:0] bus, input bit scramble,
                            output int stall_cyc, output int rsp_cyc, output int dv_first,
                            output logic [63:0] rdata, output logic [7:0] strb, output logic [63:0] dd,
                            output logic [2:0] dsz, output logic [63:0] da, output bit stable,
                            output bit done_quiet);
    int dv_cnt = 0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    stall_cyc = 0; rsp_cyc = -1; dv_first = -1; stable = 1'b1; done_quiet = 1'b0;
    rdata = '0; strb = '0; dd = '0; dsz = '0; da = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (stall) stall_cyc++;
      if (dreq_valid) begin
        dv_cnt++;
        if (dv_cnt == 1) begin
          dv_first = cyc; strb = dreq_strobe; dd = dreq_data; dsz = dreq_size; da = dreq_addr;
        end else if (dreq_strobe !== strb || dreq_data !== dd || dreq_size !== dsz || dreq_addr !== da) begin
          stable = 1'b0;
        end
        if (scramble) begin
          req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
          req_size = 3'($urandom_range(0, 7)); req_write = 1'($urandom);
        end
      end
      dresp_data_ok = dreq_valid && (dv_cnt == lat + 1);
      dresp_data = dresp_data_ok ? bus : {$urandom, $urandom};
      if (rsp_valid) begin
        rsp_cyc = cyc; rdata = rsp_rdata; done_quiet = !stall && !dreq_valid;
        break;
      end
      @(negedge clk);
    end
    dresp_data_ok = 1'b0;
  endtask

  task automatic idle_cycle(output bit rv, output logic [63:0] rd);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    rv = rsp_valid; rd = rsp_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; dresp_data_ok = 0; dresp_data = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({stall, rsp_valid, misalign, dreq_valid} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ctrl got %b want 0000", {stall, rsp_valid, misalign, dreq_valid});
    end
    vectors++;
    if (rsp_rdata !== 64'd0) begin
      miscompares++; $display("FAIL reset_rdata got %h want 0", rsp_rdata);
    end
    vectors++;
    if ({dreq_addr, dreq_size, dreq_strobe, dreq_data} !== 139'd0) begin
      miscompares++; $display("FAIL reset_dreq got %h/%h/%h/%h want 0", dreq_addr, dreq_size, dreq_strobe, dreq_data);
    end
  endtask

  task automatic test_lb_sign();
    int sc, rc, df; logic [63:0] rd, dd, da, rd2; logic [7:0] sb; logic [2:0] ds; bit st, dq, rv;
    run_access(1'b0, 3'd0, 1'b0, 64'h1003, {$urandom, $urandom}, 2, 64'h0000_0000_8000_0000, 1'b0,
               sc, rc, df, rd, sb, dd, ds, da, st, dq);
    vectors++;
    if (sc !== 4 || rc !== 4 || df !== 1) begin
      miscompares++; $display("FAIL lb_timing stall=%0d rsp_at=%0d dreq_at=%0d want 4/4/1", sc, rc, df);
    end
    vectors++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FF80) begin
      miscompares++; $display("FAIL lb_rdata got %h want ffffffffffffff80", rd);
    end
    vectors++;
    if (sb !== 8'h00 || da !== 64'h1003 || !dq) begin
      miscompares++; $display("FAIL lb_dreq strobe=%h addr=%h done_quiet=%0d want 00/1003/1", sb, da, dq);
    end
    idle_cycle(rv, rd2);
    vectors++;
    if (rv !== 1'b0 || rd2 !== rd) begin
      miscompares++; $display("FAIL lb_pulse rsp_valid=%0d rdata=%h want 0/%h", rv, rd2, rd);
    end
  endtask

  task automatic test_sh_strobe();
    int sc, rc, df; logic [63:0] rd, dd, da, rd2; logic [7:0] sb; logic [2:0] ds; bit st, dq, rv;
    run_access(1'b1, 3'd1, 1'b0, 64'h1006, 64'hBEEF, 3, {$urandom, $urandom}, 1'b1,
               sc, rc, df, rd, sb, dd, ds, da, st, dq);
    vectors++;
    if (sb !== 8'hC0 || dd !== 64'hBEEF_0000_0000_0000 || ds !== 3'd1) begin
      miscompares++; $display("FAIL sh_dreq strobe=%h data=%h size=%0d want c0/beef000000000000/1", sb, dd, ds);
    end
    vectors++;
    if (!st || sc !== 5 || rd !== 64'd0) begin
      miscompares++; $display("FAIL sh_hold stable=%0d stall=%0d rdata=%h want 1/5/0", st, sc, rd);
    end
    idle_cycle(rv, rd2);
  endtask

  task automatic test_misalign();
    logic [2:0]  szs [3] = '{3'd2, 3'd3, 3'd4};
    logic [63:0] ads [3] = '{64'h1002, 64'h1004, 64'h1000};
    for (int t = 0; t < 3; t++) begin
      req_valid = 1'b1; req_write = 1'b0; req_unsigned = 1'b0; req_size = szs[t]; req_addr = ads[t];
      #1;
      vectors++;
      if ({misalign, stall, dreq_valid} !== 3'b100) begin
        miscompares++; $display("FAIL misalign_%0d got m/s/v=%b want 100", t, {misalign, stall, dreq_valid});
      end
      for (int k = 0; k < 2; k++) begin
        @(negedge clk); #1;
        vectors++;
        if (dreq_valid !== 1'b0 || misalign !== 1'b1) begin
          miscompares++; $display("FAIL misalign_hold_%0d dreq_valid=%0d misalign=%0d want 0/1", t, dreq_valid, misalign);
        end
      end
      req_valid = 1'b0;
      #1;
      vectors++;
      if (misalign !== 1'b0) begin
        miscompares++; $display("FAIL misalign_clear_%0d got %0d want 0", t, misalign);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int sc, rc, df; logic [63:0] rd, dd, da, rd2, bus; logic [7:0] sb; logic [2:0] ds; bit st, dq, rv;
    run_access(1'b0, 3'd2, 1'b1, 64'h1004, '0, 1, 64'hF000_0000_0000_0000, 1'b0,
               sc, rc, df, rd, sb, dd, ds, da, st, dq);
    vectors++;
    if (rd !== 64'h0000_0000_F000_0000 || sc !== 3 || rc !== 3) begin
      miscompares++; $display("FAIL lwu rdata=%h stall=%0d rsp_at=%0d want 00000000f0000000/3/3", rd, sc, rc);
    end
    req_valid = 1'b1; req_write = 1'b0; req_size = 3'd3; req_unsigned = 1'b0; req_addr = 64'h2008;
    #1;
    vectors++;
    if ({stall, rsp_valid, dreq_valid} !== 3'b010) begin
      miscompares++; $display("FAIL b2b_done got s/r/v=%b want 010", {stall, rsp_valid, dreq_valid});
    end
    @(negedge clk);
    bus = {$urandom, $urandom};
    run_access(1'b0, 3'd3, 1'b0, 64'h2008, '0, 2, bus, 1'b0, sc, rc, df, rd, sb, dd, ds, da, st, dq);
    vectors++;
    if (df !== 1 || sc !== 4 || rd !== bus) begin
      miscompares++; $display("FAIL b2b_ld dreq_at=%0d stall=%0d rdata=%h want 1/4/%h", df, sc, rd, bus);
    end
    idle_cycle(rv, rd2);
  endtask

  task automatic test_reset_mid_req();
    req_valid = 1'b1; req_write = 1'b0; req_size = 3'd0; req_unsigned = 1'b0; req_addr = 64'h3000;
    @(negedge clk); #1;
    vectors++;
    if (dreq_valid !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_setup dreq_valid=%0d want 1", dreq_valid);
    end
    #1; rst = 1'b1; #1;
    vectors++;
    if (dreq_valid !== 1'b0 || stall !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_async dreq_valid=%0d stall=%0d want 0/0", dreq_valid, stall);
    end
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      vectors++;
      if ({stall, rsp_valid, misalign, dreq_valid, dreq_strobe, dreq_size} !== 15'd0 ||
          rsp_rdata !== 64'd0 || dreq_addr !== 64'd0 || dreq_data !== 64'd0) begin
        miscompares++; $display("FAIL rst_mid_after_%0d s/r/m/v=%b rdata=%h addr=%h want all 0", k,
                                {stall, rsp_valid, misalign, dreq_valid}, rsp_rdata, dreq_addr);
      end
    end
  endtask

  task automatic test_random();
    int sc, rc, df, lat; logic [63:0] rd, dd, da, rd2, addr, wd, bus; logic [7:0] sb; logic [2:0] ds, sz;
    bit st, dq, rv, w, uns;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        sz = 3'($urandom_range(1, 7));
        addr = {$urandom, $urandom};
        if (sz <= 3'd3) addr[0] = 1'b1;
        req_valid = 1'b1; req_write = 1'($urandom); req_size = sz; req_addr = addr;
        #1;
        vectors++;
        if ({misalign, stall, dreq_valid} !== 3'b100) begin
          miscompares++; $display("FAIL rnd_illegal_%0d size=%0d addr=%h m/s/v=%b want 100", n, sz, addr,
                                  {misalign, stall, dreq_valid});
        end
        @(negedge clk); #1;
        vectors++;
        if (dreq_valid !== 1'b0) begin
          miscompares++; $display("FAIL rnd_illegal_req_%0d dreq_valid=%0d want 0", n, dreq_valid);
        end
        idle_cycle(rv, rd2);
      end else begin
        sz = 3'($urandom_range(0, 3));
        addr = {$urandom, $urandom} & ~((64'd1 << sz) - 64'd1);
        w = 1'($urandom); uns = 1'($urandom); wd = {$urandom, $urandom}; bus = {$urandom, $urandom};
        lat = $urandom_range(1, 4);
        run_access(w, sz, uns, addr, wd, lat, bus, 1'b1, sc, rc, df, rd, sb, dd, ds, da, st, dq);
        vectors++;
        if (sc !== lat + 2 || rc !== lat + 2 || df !== 1 || !dq) begin
          miscompares++; $display("FAIL rnd_timing_%0d stall=%0d rsp_at=%0d dreq_at=%0d quiet=%0d want %0d/%0d/1/1",
                                  n, sc, rc, df, dq, lat + 2, lat + 2);
        end
        vectors++;
        if (sb !== m_strobe(w, int'(sz), addr) || dd !== m_wdata(wd, addr) || ds !== sz || da !== addr || !st) begin
          miscompares++; $display("FAIL rnd_dreq_%0d strobe=%h data=%h size=%0d addr=%h stable=%0d want %h/%h/%0d/%h/1",
                                  n, sb, dd, ds, da, st, m_strobe(w, int'(sz), addr), m_wdata(wd, addr), sz, addr);
        end
        vectors++;
        if (rd !== m_rdata(w, int'(sz), uns, addr, bus)) begin
          miscompares++; $display("FAIL rnd_rdata_%0d got %h want %h", n, rd, m_rdata(w, int'(sz), uns, addr, bus));
        end
        idle_cycle(rv, rd2);
        vectors++;
        if (rv !== 1'b0 || rd2 !== rd) begin
          miscompares++; $display("FAIL rnd_pulse_%0d rsp_valid=%0d rdata=%h want 0/%h", n, rv, rd2, rd);
        end
      end
    end
  endtask

`ifdef LSU_PERF_CNT_EN
  task automatic test_perf();
    int sc, rc, df; logic [63:0] rd, dd, da, rd2; logic [7:0] sb; logic [2:0] ds; bit st, dq, rv;
    logic [31:0] a0, w0;
    a0 = perf_acc_cnt; w0 = perf_wait_cyc;
    for (int k = 0; k < 3; k++) begin
      run_access(1'b0, 3'd3, 1'b0, 64'h4000 + 64'(k * 8), '0, 1, {$urandom, $urandom}, 1'b0,
                 sc, rc, df, rd, sb, dd, ds, da, st, dq);
      idle_cycle(rv, rd2);
    end
    vectors++;
    if (perf_acc_cnt - a0 !== 32'd3 || perf_wait_cyc - w0 !== 32'd6) begin
      miscompares++; $display("FAIL perf acc=%0d wait=%0d want 3/6", perf_acc_cnt - a0, perf_wait_cyc - w0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lb_sign();
    test_sh_strobe();
    test_misalign();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
`ifdef LSU_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
